// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (800x600@60, 640x480@60) and the sync/visible window decoder.
package vga_timing_pkg;

    localparam int unsigned SVGA_H_VIS  = 800;
    localparam int unsigned SVGA_H_FP   = 40;
    localparam int unsigned SVGA_H_SYNC = 128;
    localparam int unsigned SVGA_H_BP   = 88;
    localparam int unsigned SVGA_V_VIS  = 600;
    localparam int unsigned SVGA_V_FP   = 1;
    localparam int unsigned SVGA_V_SYNC = 4;
    localparam int unsigned SVGA_V_BP   = 23;

    localparam int unsigned VGA_H_VIS   = 640;
    localparam int unsigned VGA_H_FP    = 16;
    localparam int unsigned VGA_H_SYNC  = 96;
    localparam int unsigned VGA_H_BP    = 48;
    localparam int unsigned VGA_V_VIS   = 480;
    localparam int unsigned VGA_V_FP    = 10;
    localparam int unsigned VGA_V_SYNC  = 2;
    localparam int unsigned VGA_V_BP    = 33;

    // Half-open window test: lo <= val < hi.
    function automatic logic in_window(input int unsigned val, input int unsigned lo,
                                       input int unsigned hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with enable, carry-out on wrap, registered sync and
// a visible flag decoded from the count the next edge will load.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL   = 1056,
    parameter int unsigned VIS     = 800,
    parameter int unsigned SYNC_LO = 840,
    parameter int unsigned SYNC_HI = 968,
    parameter bit          POL     = 1'b1,
    parameter int unsigned W       = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         sync,
    output logic         carry,
    output logic         vis_d
);

    localparam logic [W-1:0] LAST_CNT = W'(TOTAL - 1);

    logic         last;
    logic [W-1:0] nxt;
    logic [W-1:0] d_cnt;

    assign last  = (cnt == LAST_CNT);
    assign nxt   = last ? '0 : cnt + W'(1);
    assign d_cnt = en ? nxt : cnt;
    assign carry = en & last;
    assign vis_d = in_window(32'(d_cnt), 0, VIS);

    // Sync is decoded from the count being loaded so it lines up with cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            sync <= ~POL;
        end else begin
            cnt  <= d_cnt;
            sync <= in_window(32'(d_cnt), SYNC_LO, SYNC_HI) ? POL : ~POL;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel clock-enable.
// Optional frame counter output enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VIS   = SVGA_H_VIS,
    parameter int unsigned H_FP    = SVGA_H_FP,
    parameter int unsigned H_SYNC  = SVGA_H_SYNC,
    parameter int unsigned H_BP    = SVGA_H_BP,
    parameter int unsigned V_VIS   = SVGA_V_VIS,
    parameter int unsigned V_FP    = SVGA_V_FP,
    parameter int unsigned V_SYNC  = SVGA_V_SYNC,
    parameter int unsigned V_BP    = SVGA_V_BP,
    parameter bit          H_POL   = 1'b1,
    parameter bit          V_POL   = 1'b1,
    parameter int unsigned H_W     = 11,
    parameter int unsigned V_W     = 10
`ifdef VGA_FRAME_CNT_EN
    ,
    parameter int unsigned FRAME_W = 16
`endif
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pix_ce,
    output logic [H_W-1:0] h_cnt,
    output logic [V_W-1:0] v_cnt,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic           line_start,
    output logic           frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [FRAME_W-1:0] frame_cnt
`endif
);

    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    logic h_carry;
    logic v_carry;
    logic h_vis_d;
    logic v_vis_d;

    vga_axis_counter #(
        .TOTAL  (H_TOTAL),
        .VIS    (H_VIS),
        .SYNC_LO(H_VIS + H_FP),
        .SYNC_HI(H_VIS + H_FP + H_SYNC),
        .POL    (H_POL),
        .W      (H_W)
    ) u_h (
        .clk  (clk),
        .rst  (rst),
        .en   (pix_ce),
        .cnt  (h_cnt),
        .sync (hsync),
        .carry(h_carry),
        .vis_d(h_vis_d)
    );

    // The vertical axis only steps on the horizontal wrap, so vsync moves on whole lines.
    vga_axis_counter #(
        .TOTAL  (V_TOTAL),
        .VIS    (V_VIS),
        .SYNC_LO(V_VIS + V_FP),
        .SYNC_HI(V_VIS + V_FP + V_SYNC),
        .POL    (V_POL),
        .W      (V_W)
    ) u_v (
        .clk  (clk),
        .rst  (rst),
        .en   (h_carry),
        .cnt  (v_cnt),
        .sync (vsync),
        .carry(v_carry),
        .vis_d(v_vis_d)
    );

    // Pulses are recomputed every clock, so they clear even while pix_ce is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            de          <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            de          <= h_vis_d & v_vis_d;
            line_start  <= h_carry;
            frame_start <= v_carry;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (v_carry) begin
            frame_cnt <= frame_cnt + FRAME_W'(1);
        end
    end
`endif

endmodule
